// File: rtl/cpu_pkg.sv
// Shared constants, fetch state encoding and opcode decode helpers for the 8-bit RISC core.
package cpu_pkg;

  localparam int unsigned OPW   = 5;
  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 8;

  typedef enum logic [1:0] {
    StOp,
    StOpw,
    StArgw,
    StHold
  } fetch_state_e;

  // Opcodes with the MSB set carry an operand/address byte.
  function automatic logic is_two_byte(input logic [DataW-1:0] op_byte);
    return op_byte[DataW-1];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch sequencer and instruction register: assembles 1/2-byte instructions from the ROM
// byte stream and presents them to the decoder over a valid/ready handshake.
module instr_fetch #(
  parameter int unsigned OPW = cpu_pkg::OPW
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [cpu_pkg::DataW-1:0] rom_data,
  output logic                     rom_rd,
  output logic                     pc_inc,
  input  logic                     flush,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [OPW-1:0]           ir_opcode,
  output logic [7-OPW:0]           ir_field,
  output logic [7:0]               ir_operand,
  output logic                     ir_len2
);
  import cpu_pkg::*;

  fetch_state_e     state_q;
  logic [DataW-1:0] opbyte_q;
  logic [DataW-1:0] operand_q;
  logic             len2_q;
  logic             fetch;

  // One strobe drives both the ROM read and the PC increment, so they can never diverge.
  always_comb begin
    fetch = 1'b0;
    case (state_q)
      StOp:    fetch = 1'b1;
      StOpw:   fetch = is_two_byte(rom_data);
      StHold:  fetch = ir_ready;
      default: fetch = 1'b0;
    endcase
    if (rst || flush) fetch = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= StOp;
      opbyte_q  <= '0;
      operand_q <= '0;
      len2_q    <= 1'b0;
    end else if (flush) begin
      state_q <= StOp;
    end else begin
      case (state_q)
        StOp: state_q <= StOpw;
        StOpw: begin
          opbyte_q <= rom_data;
          len2_q   <= is_two_byte(rom_data);
          if (is_two_byte(rom_data)) begin
            state_q <= StArgw;
          end else begin
            operand_q <= '0;
            state_q   <= StHold;
          end
        end
        StArgw: begin
          operand_q <= rom_data;
          state_q   <= StHold;
        end
        StHold: if (ir_ready) state_q <= StOpw;
        default: state_q <= StOp;
      endcase
    end
  end

  assign rom_rd     = fetch;
  assign pc_inc     = fetch;
  assign ir_valid   = (state_q == StHold);
  assign ir_opcode  = opbyte_q[DataW-1 -: OPW];
  assign ir_field   = opbyte_q[DataW-OPW-1:0];
  assign ir_operand = operand_q;
  assign ir_len2    = len2_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vectors, corner sequences and a randomized
// run scored against an instruction-level model of the ROM program.
module tb_instr_fetch;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] rom_data;
  logic       rom_rd;
  logic       pc_inc;
  logic       flush;
  logic       ir_valid;
  logic       ir_ready;
  logic [4:0] ir_opcode;
  logic [2:0] ir_field;
  logic [7:0] ir_operand;
  logic       ir_len2;

  logic [7:0] rom [256];
  logic [7:0] pc;
  logic [7:0] load_addr;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.OPW(5)) dut (
    .clock      (clock),
    .rst        (rst),
    .rom_data   (rom_data),
    .rom_rd     (rom_rd),
    .pc_inc     (pc_inc),
    .flush      (flush),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .ir_opcode  (ir_opcode),
    .ir_field   (ir_field),
    .ir_operand (ir_operand),
    .ir_len2    (ir_len2)
  );

  always #5 clock = ~clock;

  // Environment: program counter and synchronous ROM.
  always @(posedge clock) begin
    if (rst) pc <= 8'd0;
    else if (flush) pc <= load_addr;
    else if (pc_inc) pc <= pc + 8'd1;
    if (rom_rd) rom_data <= rom[pc];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; ir_ready = 1'b0; load_addr = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int c = 0; c < 10; c++) begin
      if (ir_valid) begin
        cyc = c;
        break;
      end
      tick();
    end
    if (cyc < 0) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  // Instruction-level scoreboard for the randomized run.
  logic       sb_en = 1'b0;
  logic [7:0] exp_pc;
  int         n_hs;

  always @(negedge clock) begin
    if (sb_en) begin
      logic [7:0] b0, b1, a1;
      check("rd_eq_inc", {31'd0, rom_rd}, {31'd0, pc_inc});
      if (flush) check("rd_on_flush", {31'd0, rom_rd}, 32'd0);
      if (ir_valid && ir_ready) begin
        b0 = rom[exp_pc];
        a1 = exp_pc + 8'd1;
        b1 = b0[7] ? rom[a1] : 8'h00;
        check("sb_opcode", {27'd0, ir_opcode}, {27'd0, b0[7:3]});
        check("sb_field", {29'd0, ir_field}, {29'd0, b0[2:0]});
        check("sb_len2", {31'd0, ir_len2}, {31'd0, b0[7]});
        check("sb_operand", {24'd0, ir_operand}, {24'd0, b1});
        exp_pc = exp_pc + (b0[7] ? 8'd2 : 8'd1);
        check("sb_ret_pc", {24'd0, pc}, {24'd0, exp_pc});
        n_hs++;
      end
      if (flush) exp_pc = load_addr;
    end
  end

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [4:0] op;
    logic [2:0] fld;
    logic [7:0] opnd;
    logic       len2;
    int         lat;
    int         incs;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   lat, incs, cyc;

    vecs[0] = '{8'h28, 8'h00, 5'h05, 3'd0, 8'h00, 1'b0, 2, 1};
    vecs[1] = '{8'hA3, 8'h7F, 5'h14, 3'd3, 8'h7F, 1'b1, 3, 2};
    vecs[2] = '{8'h00, 8'hEE, 5'h00, 3'd0, 8'h00, 1'b0, 2, 1};
    vecs[3] = '{8'hFF, 8'h01, 5'h1F, 3'd7, 8'h01, 1'b1, 3, 2};
    vecs[4] = '{8'h7F, 8'h99, 5'h0F, 3'd7, 8'h00, 1'b0, 2, 1};
    vecs[5] = '{8'h80, 8'h00, 5'h10, 3'd0, 8'h00, 1'b1, 3, 2};

    // Reset values while rst is held high.
    clear_rom();
    rst = 1'b1; flush = 1'b0; ir_ready = 1'b1; load_addr = 8'h00;
    tick();
    tick();
    check("rst_rom_rd", {31'd0, rom_rd}, 32'd0);
    check("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_opcode", {27'd0, ir_opcode}, 32'd0);
    check("rst_operand", {24'd0, ir_operand}, 32'd0);

    // Directed vectors: latency, fields and pc_inc count per instruction.
    foreach (vecs[i]) begin
      clear_rom();
      rom[0] = vecs[i].b0;
      rom[1] = vecs[i].b1;
      do_reset();
      ir_ready = 1'b1;
      #1;
      lat = -1;
      incs = 0;
      for (int c = 0; c < 10; c++) begin
        if (c == 0) check("first_rd", {31'd0, rom_rd}, 32'd1);
        if (ir_valid) begin
          lat = c;
          break;
        end
        incs += int'(pc_inc);
        tick();
      end
      check("vec_latency", lat, vecs[i].lat);
      check("vec_pc_incs", incs, vecs[i].incs);
      check("vec_opcode", {27'd0, ir_opcode}, {27'd0, vecs[i].op});
      check("vec_field", {29'd0, ir_field}, {29'd0, vecs[i].fld});
      check("vec_operand", {24'd0, ir_operand}, {24'd0, vecs[i].opnd});
      check("vec_len2", {31'd0, ir_len2}, {31'd0, vecs[i].len2});
      check("vec_pc", {24'd0, pc}, vecs[i].len2 ? 32'd2 : 32'd1);
    end

    // Back-pressure: IR frozen and no fetch while ready is low.
    clear_rom();
    rom[0] = 8'h28;
    do_reset();
    wait_valid(cyc);
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", {31'd0, ir_valid}, 32'd1);
      check("hold_opcode", {27'd0, ir_opcode}, 32'h05);
      check("hold_rd", {31'd0, rom_rd | pc_inc}, 32'd0);
      check("hold_pc", {24'd0, pc}, 32'd1);
      tick();
    end
    ir_ready = 1'b1;
    #1;
    check("hold_release_rd", {31'd0, rom_rd}, 32'd1);

    // Flush while the operand byte is in flight.
    clear_rom();
    rom[0] = 8'hA3; rom[1] = 8'h55; rom[8'h10] = 8'h28;
    do_reset();
    ir_ready = 1'b1;
    tick();
    tick();
    flush = 1'b1; load_addr = 8'h10;
    #1;
    check("argw_flush_rd", {31'd0, rom_rd}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("argw_resume_rd", {31'd0, rom_rd}, 32'd1);
    check("argw_valid_low", {31'd0, ir_valid}, 32'd0);
    tick();
    check("argw_valid_low2", {31'd0, ir_valid}, 32'd0);
    tick();
    check("argw_valid", {31'd0, ir_valid}, 32'd1);
    check("argw_opcode", {27'd0, ir_opcode}, 32'h05);
    check("argw_operand", {24'd0, ir_operand}, 32'h00);
    check("argw_pc", {24'd0, pc}, 32'h11);

    // Flush coinciding with a handshake.
    clear_rom();
    rom[0] = 8'h28; rom[8'h20] = 8'h30;
    do_reset();
    wait_valid(cyc);
    ir_ready = 1'b1; flush = 1'b1; load_addr = 8'h20;
    #1;
    check("hsflush_rd", {31'd0, rom_rd}, 32'd0);
    tick();
    flush = 1'b0; ir_ready = 1'b0;
    #1;
    check("hsflush_next_rd", {31'd0, rom_rd}, 32'd1);
    check("hsflush_valid_low", {31'd0, ir_valid}, 32'd0);
    check("hsflush_pc", {24'd0, pc}, 32'h20);
    incs = 0;
    for (int c = 0; c < 4; c++) begin
      incs += int'(pc_inc);
      tick();
    end
    check("hsflush_incs", incs, 1);
    check("hsflush_valid", {31'd0, ir_valid}, 32'd1);
    check("hsflush_opcode", {27'd0, ir_opcode}, 32'h06);
    check("hsflush_new_pc", {24'd0, pc}, 32'h21);

    // Reset mid-instruction overrides flush and ready.
    clear_rom();
    rom[0] = 8'hA3; rom[1] = 8'h7F; rom[2] = 8'h28;
    do_reset();
    ir_ready = 1'b1;
    wait_valid(cyc);
    check("pre_rst_operand", {24'd0, ir_operand}, 32'h7F);
    tick();
    rst = 1'b1; flush = 1'b1;
    #1;
    check("opw_rst_rd", {31'd0, rom_rd}, 32'd0);
    tick();
    check("opw_rst_valid", {31'd0, ir_valid}, 32'd0);
    check("opw_rst_opcode", {27'd0, ir_opcode}, 32'd0);
    check("opw_rst_field", {29'd0, ir_field}, 32'd0);
    check("opw_rst_operand", {24'd0, ir_operand}, 32'd0);
    check("opw_rst_len2", {31'd0, ir_len2}, 32'd0);
    rst = 1'b0; flush = 1'b0;
    #1;
    check("opw_rst_first_rd", {31'd0, rom_rd}, 32'd1);

    // Randomized program, ready and flush traffic against the scoreboard.
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    do_reset();
    exp_pc = 8'h00;
    n_hs = 0;
    sb_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      ir_ready  = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      load_addr = 8'($urandom);
      tick();
    end
    flush = 1'b0;
    ir_ready = 1'b0;
    @(negedge clock);
    sb_en = 1'b0;
    check("rand_progress", {31'd0, n_hs > 300}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
